// File: rtl/fifo_wr_arb_pkg.sv
// Shared state encoding, default sizing constants and a width helper for the
// FIFO write-side packet arbiter.
package fifo_wr_arb_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_MAX_PKT_LEN = 16;
  localparam int PKT_CNT_W       = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set request bit in the
// order last_grant+1, last_grant+2, ... (mod NUM_REQ).
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_valid;

  // cand_idx[gi] is the requester sitting gi+1 places after last_grant
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, last_grant} + (IDX_W+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ?
                            IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
      assign cand_valid[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) begin
        idx   = cand_idx[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter that merges NUM_REQ beat streams onto one
// FIFO write port; ownership is held from first beat to packet end.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int  NUM_REQ     = DEF_NUM_REQ,
  parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int  MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  localparam int IDX_W       = idx_width(NUM_REQ),
  localparam int BEAT_W      = $clog2(MAX_PKT_LEN) + 1
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          busy,
  output logic [PKT_CNT_W-1:0]          pkt_count,
  output logic                          err_len
);

  arb_state_e            state_reg, state_next;
  logic [IDX_W-1:0]      grant_reg, grant_next;
  logic [IDX_W-1:0]      last_grant_reg, last_grant_next;
  logic [BEAT_W-1:0]     beat_cnt_reg, beat_cnt_next;
  logic [PKT_CNT_W-1:0]  pkt_count_reg, pkt_count_next;
  logic                  err_len_reg, err_len_next;
  logic                  busy_reg, busy_next;

  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic                  in_xfer;
  logic                  owner_valid;
  logic                  owner_last;
  logic                  accept;
  logic                  len_hit;
  logic                  pkt_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = accept & (grant_reg == IDX_W'(gi));
    end
  endgenerate

  assign in_xfer     = (state_reg == XFER);
  assign owner_valid = req_valid[grant_reg];
  assign owner_last  = req_last[grant_reg];
  assign accept      = in_xfer & owner_valid & ~full;
  // beat_cnt_reg counts beats already taken, so this accept is beat MAX_PKT_LEN
  assign len_hit     = (beat_cnt_reg == BEAT_W'(MAX_PKT_LEN - 1));
  assign pkt_end     = accept & (owner_last | len_hit);

  assign wr_en     = accept;
  assign wr_data   = in_xfer ? data_arr[grant_reg] : '0;
  assign grant_id  = grant_reg;
  assign busy      = busy_reg;
  assign pkt_count = pkt_count_reg;
  assign err_len   = err_len_reg;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    pkt_count_next  = pkt_count_reg;
    err_len_next    = err_len_reg;
    case (state_reg)
      IDLE: begin
        if (|req_valid) state_next = ARB;
      end
      ARB: begin
        beat_cnt_next = '0;
        // a requester may withdraw before arbitration; fall back to IDLE then
        if (pick_found) begin
          grant_next = pick_idx;
          state_next = XFER;
        end else begin
          state_next = IDLE;
        end
      end
      XFER: begin
        if (accept) beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
        if (pkt_end) begin
          pkt_count_next  = pkt_count_reg + PKT_CNT_W'(1);
          last_grant_next = grant_reg;
          beat_cnt_next   = '0;
          if (!owner_last) err_len_next = 1'b1;
          state_next = (|req_valid) ? ARB : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      beat_cnt_reg   <= '0;
      pkt_count_reg  <= '0;
      err_len_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      pkt_count_reg  <= pkt_count_next;
      err_len_reg    <= err_len_next;
      busy_reg       <= busy_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus a randomized run checked
// against a packet-level round-robin model.
module tb_fifo_wr_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int MPL = 16;

  logic             wr_clk = 1'b0;
  logic             wr_rst = 1'b1;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic             full, wr_en, busy, err_len;
  logic [DW-1:0]    wr_data;
  logic [1:0]       grant_id;
  logic [15:0]      pkt_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] src_data [NR][$];
  bit            src_last [NR][$];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_PKT_LEN(MPL)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .full(full), .wr_en(wr_en),
    .wr_data(wr_data), .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count),
    .err_len(err_len)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    full      = 1'b0;
  endtask

  task automatic do_reset();
    wr_rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    wr_rst = 1'b0;
  endtask

  function automatic int rr_expect(input int last, input bit [NR-1:0] cand);
    for (int k = 1; k <= NR; k++)
      if (cand[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic test_reset();
    wr_rst = 1'b1;
    req_valid = '1;
    req_data  = $urandom;
    req_last  = '1;
    full      = 1'b0;
    @(negedge wr_clk);
    @(negedge wr_clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else n_pass++;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_req_ready: got %b want 0000", req_ready); else n_pass++;
    n_checks++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", wr_data); else n_pass++;
    n_checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (pkt_count !== 16'd0) $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); else n_pass++;
    n_checks++; if (err_len !== 1'b0) $display("FAIL reset_err_len: got %b want 0", err_len); else n_pass++;
    tick();
    wr_rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    int k = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = (k < 3) ? 4'b0001 : 4'b0000;
      req_data  = {24'h0, 8'hA0 + 8'(k)};
      req_last  = (k == 2) ? 4'b0001 : 4'b0000;
      @(negedge wr_clk);
      n_checks++;
      if (wr_en !== (c >= 2 && c <= 4)) $display("FAIL single_wr_en c=%0d: got %b want %b", c, wr_en, (c >= 2 && c <= 4));
      else n_pass++;
      if (wr_en) begin
        n_checks++; if (wr_data !== 8'hA0 + 8'(k)) $display("FAIL single_data: got %h want %h", wr_data, 8'hA0 + 8'(k)); else n_pass++;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready); else n_pass++;
        k++;
      end
      if (c == 1) begin n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_arb: got %b want 1", busy); else n_pass++; end
      if (c == 5) begin n_checks++; if (pkt_count !== 16'd1) $display("FAIL single_pkt_count: got %0d want 1", pkt_count); else n_pass++; end
      if (c == 6) begin n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_end: got %b want 0", busy); else n_pass++; end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int beat[NR];
    int pkts = 0;
    int c_done = -1;
    int exp_owner;
    do_reset();
    for (int i = 0; i < NR; i++) beat[i] = 0;
    for (int c = 0; c < 40 && pkts < 5; c++) begin
      req_valid = '1;
      full = 1'b0;
      for (int i = 0; i < NR; i++) begin
        req_data[i*DW +: DW] = {4'(i), 4'(beat[i])};
        req_last[i] = beat[i][0];
      end
      @(negedge wr_clk);
      if (c > 0) begin n_checks++; if (busy !== 1'b1) $display("FAIL rr_busy c=%0d: got %b want 1", c, busy); else n_pass++; end
      if (wr_en) begin
        exp_owner = pkts % NR;
        n_checks++; if (int'(grant_id) != exp_owner) $display("FAIL rr_grant: got %0d want %0d", grant_id, exp_owner); else n_pass++;
        n_checks++;
        if (wr_data !== {4'(exp_owner), 4'(beat[exp_owner])}) $display("FAIL rr_data: got %h want %h", wr_data, {4'(exp_owner), 4'(beat[exp_owner])});
        else n_pass++;
      end
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) begin
          beat[i]++;
          if (beat[i] % 2 == 0) begin pkts++; c_done = c; end
        end
      end
      tick();
    end
    req_valid = '0;
    @(negedge wr_clk);
    n_checks++; if (pkts != 5) $display("FAIL rr_packets: got %0d want 5", pkts); else n_pass++;
    n_checks++; if (c_done != 15) $display("FAIL rr_timing: last beat cycle %0d want 15", c_done); else n_pass++;
    n_checks++; if (pkt_count !== 16'd5) $display("FAIL rr_pkt_count: got %0d want 5", pkt_count); else n_pass++;
    tick();
  endtask

  task automatic test_full_stall();
    int k = 0;
    int stalls = 0;
    do_reset();
    for (int c = 0; c < 40 && k < 6; c++) begin
      req_valid = '0; req_valid[2] = 1'b1; req_valid[1] = (c >= 2);
      req_data  = '0; req_data[2*DW +: DW] = 8'h20 + 8'(k); req_data[1*DW +: DW] = 8'h11;
      req_last  = '0; req_last[2] = (k == 5); req_last[1] = 1'b1;
      full = (k == 2 && stalls < 4);
      @(negedge wr_clk);
      if (full) begin
        n_checks++; if (wr_en !== 1'b0) $display("FAIL stall_wr_en: got %b want 0", wr_en); else n_pass++;
        n_checks++; if (req_ready !== 4'b0) $display("FAIL stall_ready: got %b want 0000", req_ready); else n_pass++;
        n_checks++; if (grant_id !== 2'd2) $display("FAIL stall_grant: got %0d want 2", grant_id); else n_pass++;
        stalls++;
      end else if (c >= 2) begin
        n_checks++; if (wr_en !== 1'b1) $display("FAIL stall_beat_en k=%0d: got %b want 1", k, wr_en); else n_pass++;
        n_checks++; if (wr_data !== 8'h20 + 8'(k)) $display("FAIL stall_data: got %h want %h", wr_data, 8'h20 + 8'(k)); else n_pass++;
        n_checks++; if (req_ready !== 4'b0100) $display("FAIL stall_beat_ready: got %b want 0100", req_ready); else n_pass++;
      end
      if (wr_en) k++;
      tick();
    end
    full = 1'b0;
    n_checks++; if (k != 6 || stalls != 4) $display("FAIL stall_done: beats %0d stalls %0d want 6 and 4", k, stalls); else n_pass++;
  endtask

  task automatic test_gap();
    int k = 0;
    int gaps = 0;
    bit gap;
    do_reset();
    for (int c = 0; c < 40 && k < 5; c++) begin
      gap = (k == 2 && gaps < 3);
      req_valid = 4'b0010; req_valid[0] = ~gap;
      req_data  = '0; req_data[DW-1:0] = 8'h40 + 8'(k); req_data[1*DW +: DW] = 8'h11;
      req_last  = 4'b0010; req_last[0] = (k == 4);
      @(negedge wr_clk);
      if (gap) begin
        n_checks++; if (wr_en !== 1'b0 || req_ready !== 4'b0) $display("FAIL gap_idle: got wr_en %b ready %b want 0 0000", wr_en, req_ready); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL gap_grant: got %0d want 0", grant_id); else n_pass++;
        gaps++;
      end else if (c >= 2) begin
        n_checks++; if (wr_en !== 1'b1 || req_ready !== 4'b0001) $display("FAIL gap_beat k=%0d: got wr_en %b ready %b want 1 0001", k, wr_en, req_ready); else n_pass++;
        n_checks++; if (wr_data !== 8'h40 + 8'(k)) $display("FAIL gap_data: got %h want %h", wr_data, 8'h40 + 8'(k)); else n_pass++;
      end
      if (wr_en) k++;
      tick();
    end
    req_valid = 4'b0010;
    @(negedge wr_clk);
    n_checks++; if (k != 5 || wr_en !== 1'b0) $display("FAIL gap_end: beats %0d wr_en %b want 5 0", k, wr_en); else n_pass++;
    tick();
    @(negedge wr_clk);
    n_checks++; if (grant_id !== 2'd1 || wr_en !== 1'b1 || wr_data !== 8'h11) $display("FAIL gap_next: grant %0d wr_en %b data %h want 1 1 11", grant_id, wr_en, wr_data); else n_pass++;
    tick();
  endtask

  task automatic test_err_len();
    int k = 0;
    do_reset();
    for (int c = 0; c < 40 && k < MPL; c++) begin
      req_valid = 4'b0011;
      req_data  = '0; req_data[DW-1:0] = 8'h60 + 8'(k); req_data[1*DW +: DW] = 8'h1F;
      req_last  = 4'b0010;
      @(negedge wr_clk);
      n_checks++; if (wr_en !== (c >= 2)) $display("FAIL err_wr_en c=%0d: got %b want %b", c, wr_en, (c >= 2)); else n_pass++;
      if (wr_en) begin
        n_checks++; if (grant_id !== 2'd0 || wr_data !== 8'h60 + 8'(k)) $display("FAIL err_beat: grant %0d data %h want 0 %h", grant_id, wr_data, 8'h60 + 8'(k)); else n_pass++;
      end
      if (k == MPL - 1) begin n_checks++; if (err_len !== 1'b0) $display("FAIL err_early: got %b want 0", err_len); else n_pass++; end
      if (wr_en) k++;
      tick();
    end
    req_valid = 4'b0010;
    @(negedge wr_clk);
    n_checks++; if (err_len !== 1'b1) $display("FAIL err_flag: got %b want 1", err_len); else n_pass++;
    n_checks++; if (pkt_count !== 16'd1) $display("FAIL err_pkt_count: got %0d want 1", pkt_count); else n_pass++;
    tick();
    @(negedge wr_clk);
    n_checks++; if (grant_id !== 2'd1 || wr_en !== 1'b1 || wr_data !== 8'h1F) $display("FAIL err_next: grant %0d wr_en %b data %h want 1 1 1f", grant_id, wr_en, wr_data); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    // requester 1 takes a one-beat packet so arbitration history is non-default
    req_valid = 4'b0010; req_last = 4'b0010; req_data = '0; req_data[1*DW +: DW] = 8'h55;
    tick();
    tick();
    @(negedge wr_clk);
    n_checks++; if (wr_en !== 1'b1 || wr_data !== 8'h55) $display("FAIL rm_pre: wr_en %b data %h want 1 55", wr_en, wr_data); else n_pass++;
    tick();
    req_valid = 4'b0001; req_last = '0; req_data = '0; req_data[DW-1:0] = 8'h70;
    tick();
    @(negedge wr_clk);
    n_checks++; if (wr_en !== 1'b1 || grant_id !== 2'd0 || wr_data !== 8'h70) $display("FAIL rm_beat1: wr_en %b grant %0d data %h want 1 0 70", wr_en, grant_id, wr_data); else n_pass++;
    tick();
    req_data[DW-1:0] = 8'h71;
    @(negedge wr_clk);
    #1 wr_rst = 1'b1;
    #1;
    n_checks++; if (wr_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) $display("FAIL rm_abort: wr_en %b ready %b busy %b want 0 0000 0", wr_en, req_ready, busy); else n_pass++;
    n_checks++; if (grant_id !== 2'd0 || wr_data !== 8'h00 || pkt_count !== 16'd0) $display("FAIL rm_regs: grant %0d data %h count %0d want 0 00 0", grant_id, wr_data, pkt_count); else n_pass++;
    tick();
    wr_rst = 1'b0;
    req_valid = 4'b0101; req_data = '0; req_data[DW-1:0] = 8'h70; req_data[2*DW +: DW] = 8'h90;
    tick();
    tick();
    @(negedge wr_clk);
    n_checks++; if (grant_id !== 2'd0 || wr_en !== 1'b1 || wr_data !== 8'h70) $display("FAIL rm_regrant: grant %0d wr_en %b data %h want 0 1 70", grant_id, wr_en, wr_data); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int pkt_left[NR];
    int owner = -1;
    int beats = 0;
    int last_g = NR - 1;
    int exp_pkts = 0;
    bit exp_err = 1'b0;
    bit open = 1'b0;
    bit done = 1'b0;
    bit [NR-1:0] cand;
    logic [NR-1:0] exp_rdy;
    int len;
    bit err;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      src_data[i].delete();
      src_last[i].delete();
      pkt_left[i] = $urandom_range(1, 3);
      for (int p = 0; p < pkt_left[i]; p++) begin
        err = ($urandom_range(0, 7) == 0);
        len = err ? MPL : $urandom_range(1, 5);
        for (int b = 0; b < len; b++) begin
          src_data[i].push_back(8'($urandom_range(0, 255)));
          src_last[i].push_back(!err && b == len - 1);
        end
      end
    end
    for (int c = 0; c < 3000 && !done; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (src_data[i].size() > 0) begin
          req_valid[i] = (open && owner == i) ? ($urandom_range(0, 3) != 0) : 1'b1;
          req_data[i*DW +: DW] = src_data[i][0];
          req_last[i] = src_last[i][0];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DW +: DW] = '0;
          req_last[i] = 1'b0;
        end
      end
      full = ($urandom_range(0, 4) == 0);
      @(negedge wr_clk);
      if (!open && wr_en) begin
        for (int i = 0; i < NR; i++) cand[i] = (pkt_left[i] > 0);
        owner = rr_expect(last_g, cand);
        open = 1'b1;
        beats = 0;
        n_checks++; if (int'(grant_id) != owner) $display("FAIL rnd_grant: got %0d want %0d", grant_id, owner); else n_pass++;
      end else if (open) begin
        n_checks++;
        if (wr_en !== (req_valid[owner] & ~full)) $display("FAIL rnd_accept: got %b want %b", wr_en, (req_valid[owner] & ~full));
        else n_pass++;
      end
      if (wr_en && open && owner >= 0 && src_data[owner].size() > 0) begin
        exp_rdy = '0;
        exp_rdy[owner] = 1'b1;
        n_checks++; if (wr_data !== src_data[owner][0]) $display("FAIL rnd_data: got %h want %h", wr_data, src_data[owner][0]); else n_pass++;
        n_checks++; if (req_ready !== exp_rdy) $display("FAIL rnd_ready: got %b want %b", req_ready, exp_rdy); else n_pass++;
        beats++;
        if (src_last[owner][0] || beats == MPL) begin
          if (!src_last[owner][0]) exp_err = 1'b1;
          exp_pkts++;
          last_g = owner;
          pkt_left[owner]--;
          open = 1'b0;
          $display("pkt %0d: requester %0d, %0d beats, last=%0b", exp_pkts, owner, beats, src_last[owner][0]);
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i] && src_data[i].size() > 0) begin
          void'(src_data[i].pop_front());
          void'(src_last[i].pop_front());
        end
      end
      tick();
      done = !open;
      for (int i = 0; i < NR; i++) if (src_data[i].size() > 0) done = 1'b0;
    end
    n_checks++; if (!done) $display("FAIL rnd_timeout: got unfinished want drained"); else n_pass++;
    idle_inputs();
    tick();
    tick();
    @(negedge wr_clk);
    n_checks++; if (pkt_count !== 16'(exp_pkts)) $display("FAIL rnd_pkt_count: got %0d want %0d", pkt_count, exp_pkts); else n_pass++;
    n_checks++; if (err_len !== exp_err) $display("FAIL rnd_err_len: got %b want %b", err_len, exp_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rnd_busy: got %b want 0", busy); else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_gap();
    test_err_len();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
